// File: rtl/td4_pkg.sv
// Shared types for the TD4 control stage: opcodes, mux selects, FSM states
// and the decoded-instruction record.
package td4_pkg;

    typedef enum logic [3:0] {
        OP_ADD_A_IM = 4'h0,
        OP_MOV_A_B  = 4'h1,
        OP_IN_A     = 4'h2,
        OP_MOV_A_IM = 4'h3,
        OP_MOV_B_A  = 4'h4,
        OP_ADD_B_IM = 4'h5,
        OP_IN_B     = 4'h6,
        OP_MOV_B_IM = 4'h7,
        OP_OUT_B    = 4'h9,
        OP_OUT_IM   = 4'hB,
        OP_JNC      = 4'hE,
        OP_JMP      = 4'hF
    } opcode_e;

    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_IN   = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_e;

    typedef struct packed {
        logic       ld_a;
        logic       ld_b;
        logic       ld_out;
        logic       ld_pc_uncond;
        logic       ld_pc_nc;
        logic [1:0] sel;
    } decode_t;

    // JNC looks at the flag left by the previous instruction, never the live adder carry.
    function automatic logic jump_taken(input decode_t dec, input logic carry_flag);
        return dec.ld_pc_uncond | (dec.ld_pc_nc & ~carry_flag);
    endfunction

endpackage

// File: rtl/td4_control_if.sv
// Bus between the TD4 control stage (master) and the datapath/ROM side (slave).
interface td4_control_if;

    logic       run_req;
    logic       step;
    logic [7:0] rom_data;
    logic [3:0] pc;
    logic       adder_cout;

    logic [1:0] sel;
    logic [3:0] imm;
    logic       n_ld_a;
    logic       n_ld_b;
    logic       n_ld_out;
    logic       n_ld_pc;
    logic [3:0] pc_load_val;
    logic       carry;
    logic       halted;
    logic [7:0] instr;

    modport master (
        input  run_req, step, rom_data, pc, adder_cout,
        output sel, imm, n_ld_a, n_ld_b, n_ld_out, n_ld_pc,
               pc_load_val, carry, halted, instr
    );

    modport slave (
        output run_req, step, rom_data, pc, adder_cout,
        input  sel, imm, n_ld_a, n_ld_b, n_ld_out, n_ld_pc,
               pc_load_val, carry, halted, instr
    );

endinterface

// File: rtl/td4_decode.sv
// Combinational TD4 opcode decoder: opcode -> register loads and mux source.
module td4_decode
    import td4_pkg::*;
(
    input  logic [3:0] i_opcode,
    output decode_t    o_dec
);

    // Opcode table; anything unlisted is a NOP that still updates carry.
    always_comb begin
        o_dec = '{ld_a: 1'b0, ld_b: 1'b0, ld_out: 1'b0,
                  ld_pc_uncond: 1'b0, ld_pc_nc: 1'b0, sel: SEL_ZERO};
        case (opcode_e'(i_opcode))
            OP_ADD_A_IM: begin o_dec.ld_a   = 1'b1; o_dec.sel = SEL_A;    end
            OP_MOV_A_B:  begin o_dec.ld_a   = 1'b1; o_dec.sel = SEL_B;    end
            OP_IN_A:     begin o_dec.ld_a   = 1'b1; o_dec.sel = SEL_IN;   end
            OP_MOV_A_IM: begin o_dec.ld_a   = 1'b1; o_dec.sel = SEL_ZERO; end
            OP_MOV_B_A:  begin o_dec.ld_b   = 1'b1; o_dec.sel = SEL_A;    end
            OP_ADD_B_IM: begin o_dec.ld_b   = 1'b1; o_dec.sel = SEL_B;    end
            OP_IN_B:     begin o_dec.ld_b   = 1'b1; o_dec.sel = SEL_IN;   end
            OP_MOV_B_IM: begin o_dec.ld_b   = 1'b1; o_dec.sel = SEL_ZERO; end
            OP_OUT_B:    begin o_dec.ld_out = 1'b1; o_dec.sel = SEL_B;    end
            OP_OUT_IM:   begin o_dec.ld_out = 1'b1; o_dec.sel = SEL_ZERO; end
            OP_JNC:      begin o_dec.ld_pc_nc     = 1'b1; o_dec.sel = SEL_ZERO; end
            OP_JMP:      begin o_dec.ld_pc_uncond = 1'b1; o_dec.sel = SEL_ZERO; end
            default:     begin o_dec.sel = SEL_ZERO; end
        endcase
    end

endmodule

// File: rtl/td4_control.sv
// TD4 control stage: HALT/FETCH/EXEC sequencer, instruction register, carry flag
// and EXEC-gated active-low load enables for the downstream datapath.
module td4_control
    import td4_pkg::*;
#(
    parameter bit START_RUNNING = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    td4_control_if.master bus
);

    localparam state_e RESET_STATE = START_RUNNING ? FETCH : HALT;

    state_e     r_state;
    logic [7:0] r_ir;
    logic [1:0] r_sel;
    logic       r_carry;
    logic       r_step_mode;
    logic       r_n_ld_a;
    logic       r_n_ld_b;
    logic       r_n_ld_out;
    logic       r_n_ld_pc;
    logic       r_jump;

    decode_t    w_dec;
    logic       w_jump;

    // Decode the ROM word during FETCH so every EXEC-cycle control is a flop output.
    td4_decode u_decode (
        .i_opcode (bus.rom_data[7:4]),
        .o_dec    (w_dec)
    );

    assign w_jump = jump_taken(w_dec, r_carry);

    // Sequencer, IR, carry flag and registered load enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RESET_STATE;
            r_ir        <= 8'h00;
            r_sel       <= SEL_A;
            r_carry     <= 1'b0;
            r_step_mode <= 1'b0;
            r_n_ld_a    <= 1'b1;
            r_n_ld_b    <= 1'b1;
            r_n_ld_out  <= 1'b1;
            r_n_ld_pc   <= 1'b0;
            r_jump      <= 1'b0;
        end else begin
            case (r_state)
                HALT: begin
                    r_n_ld_a   <= 1'b1;
                    r_n_ld_b   <= 1'b1;
                    r_n_ld_out <= 1'b1;
                    r_n_ld_pc  <= 1'b0;
                    r_jump     <= 1'b0;
                    if (bus.step) begin
                        r_state     <= FETCH;
                        r_step_mode <= 1'b1;
                    end else if (bus.run_req) begin
                        r_state     <= FETCH;
                        r_step_mode <= 1'b0;
                    end else begin
                        r_state     <= HALT;
                    end
                end
                FETCH: begin
                    r_ir       <= bus.rom_data;
                    r_sel      <= w_dec.sel;
                    r_n_ld_a   <= ~w_dec.ld_a;
                    r_n_ld_b   <= ~w_dec.ld_b;
                    r_n_ld_out <= ~w_dec.ld_out;
                    r_n_ld_pc  <= ~w_jump;
                    r_jump     <= w_jump;
                    r_state    <= EXEC;
                end
                EXEC: begin
                    r_carry    <= bus.adder_cout;
                    r_n_ld_a   <= 1'b1;
                    r_n_ld_b   <= 1'b1;
                    r_n_ld_out <= 1'b1;
                    r_n_ld_pc  <= 1'b0;
                    r_jump     <= 1'b0;
                    r_state    <= (r_step_mode || !bus.run_req) ? HALT : FETCH;
                end
                default: begin
                    r_n_ld_a   <= 1'b1;
                    r_n_ld_b   <= 1'b1;
                    r_n_ld_out <= 1'b1;
                    r_n_ld_pc  <= 1'b0;
                    r_jump     <= 1'b0;
                    r_state    <= HALT;
                end
            endcase
        end
    end

    assign bus.sel         = r_sel;
    assign bus.imm         = r_ir[3:0];
    assign bus.instr       = r_ir;
    assign bus.carry       = r_carry;
    assign bus.n_ld_a      = r_n_ld_a;
    assign bus.n_ld_b      = r_n_ld_b;
    assign bus.n_ld_out    = r_n_ld_out;
    assign bus.n_ld_pc     = r_n_ld_pc;
    // Outside a taken jump the PC is reloaded with itself, which holds it.
    assign bus.pc_load_val = r_jump ? r_ir[3:0] : bus.pc;
    assign bus.halted      = (r_state == HALT);

endmodule

// File: tb/tb_td4_control.sv
// Directed bench for td4_control: a behavioural TD4 datapath and ROM around the DUT,
// with expected values queued per step and checked by immediate assertions.
`timescale 1ns/1ps
module tb_td4_control;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    td4_control_if bus ();
    td4_control_if bus_h ();

    td4_control #(.START_RUNNING(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    td4_control #(.START_RUNNING(1'b0)) u_dut_h (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_h)
    );

    // Datapath around the main DUT: A/B/OUT/PC registers, source mux, adder, ROM.
    logic [7:0] rom [16];
    logic [3:0] dp_a, dp_b, dp_out, dp_pc;
    logic [3:0] in_port;
    logic [3:0] src;
    logic [4:0] sum;

    always_comb begin
        case (bus.sel)
            2'd0:    src = dp_a;
            2'd1:    src = dp_b;
            2'd2:    src = in_port;
            default: src = 4'd0;
        endcase
        sum = {1'b0, src} + {1'b0, bus.imm};
    end

    assign bus.rom_data   = rom[dp_pc];
    assign bus.pc         = dp_pc;
    assign bus.adder_cout = sum[4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_a   <= 4'd0;
            dp_b   <= 4'd0;
            dp_out <= 4'd0;
            dp_pc  <= 4'd0;
        end else begin
            if (!bus.n_ld_a)   dp_a   <= sum[3:0];
            if (!bus.n_ld_b)   dp_b   <= sum[3:0];
            if (!bus.n_ld_out) dp_out <= sum[3:0];
            dp_pc <= bus.n_ld_pc ? dp_pc + 4'd1 : bus.pc_load_val;
        end
    end

    // The halt-reset instance only needs quiet inputs.
    assign bus_h.run_req    = 1'b0;
    assign bus_h.step       = 1'b0;
    assign bus_h.rom_data   = 8'h33;
    assign bus_h.pc         = 4'd0;
    assign bus_h.adder_cout = 1'b0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q [$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rom_fill_nop();
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    endtask

    // Leaves the bench at mid-cycle 1 (FETCH of ROM[0] when running).
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] mask;
    int         cnt;

    initial begin
        reset   = 1'b1;
        in_port = 4'h6;
        bus.run_req = 1'b1;
        bus.step    = 1'b0;
        rom_fill_nop();

        // Reset values while reset is held
        @(negedge clk);
        expect_val("rst_instr", 8'h00);
        expect_val("rst_carry", 8'h00);
        expect_val("rst_loads", 8'h0E);
        expect_val("rst_sel",   8'h00);
        expect_val("rst_imm",   8'h00);
        expect_val("rst_halted_run", 8'h00);
        expect_val("rst_halted_halt", 8'h01);
        check(bus.instr);
        check(8'(bus.carry));
        check(8'({bus.n_ld_a, bus.n_ld_b, bus.n_ld_out, bus.n_ld_pc}));
        check(8'(bus.sel));
        check(8'(bus.imm));
        check(8'(bus.halted));
        check(8'(bus_h.halted));

        // MOV A,3 ; ADD A,4
        rom_fill_nop();
        rom[0] = 8'h33;
        rom[1] = 8'h04;
        do_reset();
        expect_val("t1_ld_a_mask", 8'h0A);
        expect_val("t1_a",   8'h07);
        expect_val("t1_carry", 8'h00);
        expect_val("t1_pc",  8'h02);
        mask = 4'd0;
        for (int c = 0; c < 4; c++) begin
            mask[c] = ~bus.n_ld_a;
            tick(1);
        end
        check(8'(mask));
        check(8'(dp_a));
        check(8'(bus.carry));
        check(8'(dp_pc));

        // Carry and JNC: not taken after overflow, taken after MOV clears carry
        rom_fill_nop();
        rom[0] = 8'h31;
        rom[1] = 8'h0F;
        rom[2] = 8'hE5;
        rom[3] = 8'h30;
        rom[4] = 8'hE7;
        do_reset();
        expect_val("t2_add_a", 8'h00);
        expect_val("t2_add_carry", 8'h01);
        expect_val("t2_jnc_not_taken_pc", 8'h03);
        expect_val("t2_mov_carry", 8'h00);
        expect_val("t2_jnc_taken_pc", 8'h07);
        tick(4);
        check(8'(dp_a));
        check(8'(bus.carry));
        tick(2);
        check(8'(dp_pc));
        tick(2);
        check(8'(bus.carry));
        tick(2);
        check(8'(dp_pc));

        // JMP 10
        rom_fill_nop();
        rom[0] = 8'hFA;
        do_reset();
        expect_val("t3_n_ld_pc", 8'h00);
        expect_val("t3_pc_load_val", 8'h0A);
        expect_val("t3_pc_after", 8'h0A);
        expect_val("t3_pc_hold", 8'h0A);
        expect_val("t3_no_reg_load", 8'h00);
        cnt = 0;
        cnt += (bus.n_ld_a & bus.n_ld_b & bus.n_ld_out) ? 0 : 1;
        tick(1);
        check(8'(bus.n_ld_pc));
        check(8'(bus.pc_load_val));
        cnt += (bus.n_ld_a & bus.n_ld_b & bus.n_ld_out) ? 0 : 1;
        tick(1);
        check(8'(dp_pc));
        cnt += (bus.n_ld_a & bus.n_ld_b & bus.n_ld_out) ? 0 : 1;
        tick(1);
        check(8'(dp_pc));
        check(8'(cnt));

        // OUT 9 ; IN B,2 ; OUT B
        rom_fill_nop();
        rom[0] = 8'hB9;
        rom[1] = 8'h62;
        rom[2] = 8'h90;
        do_reset();
        expect_val("t4_sel", 8'h03);
        expect_val("t4_imm", 8'h09);
        expect_val("t4_out_im", 8'h09);
        expect_val("t4_n_ld_out_count", 8'h01);
        expect_val("t4_in_b", 8'h08);
        expect_val("t4_out_b", 8'h08);
        cnt = 0;
        cnt += bus.n_ld_out ? 0 : 1;
        tick(1);
        check(8'(bus.sel));
        check(8'(bus.imm));
        cnt += bus.n_ld_out ? 0 : 1;
        tick(1);
        check(8'(dp_out));
        cnt += bus.n_ld_out ? 0 : 1;
        tick(1);
        cnt += bus.n_ld_out ? 0 : 1;
        check(8'(cnt));
        tick(3);
        check(8'(dp_b));
        check(8'(dp_out));

        // run_req dropped in FETCH, then single-step behaviour
        rom_fill_nop();
        do_reset();
        bus.run_req = 1'b0;
        expect_val("t5_exec_not_halted", 8'h00);
        expect_val("t5_halted", 8'h01);
        expect_val("t5_halt_pc", 8'h01);
        expect_val("t5_halt_unstable", 8'h00);
        tick(1);
        check(8'(bus.halted));
        tick(1);
        check(8'(bus.halted));
        check(8'(dp_pc));
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            cnt += (bus.halted && dp_pc == 4'd1) ? 0 : 1;
        end
        check(8'(cnt));

        expect_val("t5_step_busy_cycles", 8'h02);
        expect_val("t5_step_pc", 8'h02);
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            cnt += bus.halted ? 0 : 1;
            tick(1);
        end
        check(8'(cnt));
        check(8'(dp_pc));

        expect_val("t5_step_wins_halted", 8'h01);
        expect_val("t5_step_wins_pc", 8'h03);
        bus.run_req = 1'b1;
        bus.step    = 1'b1;
        tick(1);
        bus.step    = 1'b0;
        tick(2);
        check(8'(bus.halted));
        check(8'(dp_pc));

        // Running again: a step pulse mid-run must not halt it
        expect_val("t5_step_running_halts", 8'h00);
        tick(1);
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            cnt += bus.halted ? 1 : 0;
        end
        check(8'(cnt));

        // Reset asserted mid-EXEC of ADD A,5 while carry is set
        rom_fill_nop();
        rom[0] = 8'h3F;
        rom[1] = 8'h01;
        rom[2] = 8'h05;
        bus.run_req = 1'b1;
        do_reset();
        expect_val("t6_exec_n_ld_a", 8'h00);
        expect_val("t6_carry_before", 8'h01);
        expect_val("t6_async_n_ld_a", 8'h01);
        expect_val("t6_async_instr", 8'h00);
        expect_val("t6_async_carry", 8'h00);
        expect_val("t6_state_run", 8'h00);
        expect_val("t6_state_halt", 8'h01);
        tick(5);
        check(8'(bus.n_ld_a));
        check(8'(bus.carry));
        reset = 1'b1;
        #1;
        check(8'(bus.n_ld_a));
        check(bus.instr);
        check(8'(bus.carry));
        @(negedge clk);
        check(8'(bus.halted));
        check(8'(bus_h.halted));
        reset = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
